// File: rtl/bank_arbiter_if.sv
// Client request/response and SRAM bank pin bundle for bank_arbiter.
// slave = arbiter side, master = clients plus bank model side.
interface bank_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
);
    logic              c0_req_valid;
    logic              c0_req_write;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [DATA_W-1:0] c0_req_data;
    logic [DATA_W-1:0] c0_req_bw;
    logic              c0_req_ready;
    logic              c0_rsp_valid;
    logic [DATA_W-1:0] c0_rsp_data;

    logic              c1_req_valid;
    logic              c1_req_write;
    logic [ADDR_W-1:0] c1_req_addr;
    logic [DATA_W-1:0] c1_req_data;
    logic [DATA_W-1:0] c1_req_bw;
    logic              c1_req_ready;
    logic              c1_rsp_valid;
    logic [DATA_W-1:0] c1_rsp_data;

    logic              init_done;

    logic [DATA_W-1:0] vsi_inputData;
    logic [ADDR_W-1:0] vsi_inputAddr;
    logic              vsi_inputChipSelect;
    logic [DATA_W-1:0] vsi_bw;
    logic              vsi_outputChipSelect;
    logic [ADDR_W-1:0] vsi_outputAddr;
    logic [DATA_W-1:0] vsi_outputData;

    modport slave (
        input  c0_req_valid, c0_req_write, c0_req_addr, c0_req_data, c0_req_bw,
        input  c1_req_valid, c1_req_write, c1_req_addr, c1_req_data, c1_req_bw,
        input  vsi_outputData,
        output c0_req_ready, c0_rsp_valid, c0_rsp_data,
        output c1_req_ready, c1_rsp_valid, c1_rsp_data,
        output init_done,
        output vsi_inputData, vsi_inputAddr, vsi_inputChipSelect, vsi_bw,
        output vsi_outputChipSelect, vsi_outputAddr
    );

    modport master (
        output c0_req_valid, c0_req_write, c0_req_addr, c0_req_data, c0_req_bw,
        output c1_req_valid, c1_req_write, c1_req_addr, c1_req_data, c1_req_bw,
        output vsi_outputData,
        input  c0_req_ready, c0_rsp_valid, c0_rsp_data,
        input  c1_req_ready, c1_rsp_valid, c1_rsp_data,
        input  init_done,
        input  vsi_inputData, vsi_inputAddr, vsi_inputChipSelect, vsi_bw,
        input  vsi_outputChipSelect, vsi_outputAddr
    );
endinterface

// File: rtl/bank_arbiter.sv
// Two-client round-robin arbiter for a 1R1W SRAM bank with optional zero-fill after reset.
// Define BANK_ARB_FWD_EN to forward full-mask write data to a colliding read instead of stalling it.
module bank_arbiter #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 128,
    parameter int DEPTH         = 128,
    parameter int INIT_ON_RESET = 1
) (
    input  logic          vsi_clk,
    input  logic          vsi_reset_n,
    bank_arbiter_if.slave bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_rr_w, r_rr_r;
    logic              r_rsp_vld, r_rsp_id;

    logic [1:0]             w_valid, w_write, w_wcand, w_rcand;
    logic [1:0][ADDR_W-1:0] w_addr;
    logic [1:0][DATA_W-1:0] w_data, w_bw;
    logic                   w_run, w_wgnt, w_rgnt, w_wid, w_rid;
    logic                   w_coll, w_fwd, w_racc, w_rissue;
    logic [DATA_W-1:0]      w_rdata;

    assign w_valid = {bus.c1_req_valid, bus.c0_req_valid};
    assign w_write = {bus.c1_req_write, bus.c0_req_write};
    assign w_addr  = {bus.c1_req_addr,  bus.c0_req_addr};
    assign w_data  = {bus.c1_req_data,  bus.c0_req_data};
    assign w_bw    = {bus.c1_req_bw,    bus.c0_req_bw};

    // Gating with the raw reset keeps every output low while reset is held.
    assign w_run   = (r_state == ST_RUN) & vsi_reset_n;
    assign w_wcand = w_valid & w_write;
    assign w_rcand = w_valid & ~w_write;

    assign w_wgnt  = w_run & (|w_wcand);
    assign w_rgnt  = w_run & (|w_rcand);
    assign w_wid   = (w_wcand == 2'b11) ? r_rr_w : w_wcand[1];
    assign w_rid   = (w_rcand == 2'b11) ? r_rr_r : w_rcand[1];

    assign w_coll   = w_wgnt & w_rgnt & (w_addr[w_rid] == w_addr[w_wid]);
    assign w_racc   = w_rgnt & (~w_coll | w_fwd);
    assign w_rissue = w_rgnt & ~w_coll;

`ifdef BANK_ARB_FWD_EN
    logic              r_fwd;
    logic [DATA_W-1:0] r_fwd_data;

    assign w_fwd   = w_coll & (&w_bw[w_wid]);
    assign w_rdata = r_fwd ? r_fwd_data : bus.vsi_outputData;

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd <= w_fwd;
            if (w_fwd) r_fwd_data <= w_data[w_wid];
        end
    end
`else
    assign w_fwd   = 1'b0;
    assign w_rdata = bus.vsi_outputData;
`endif

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt              = r_state;
        bus.vsi_inputChipSelect  = 1'b0;
        bus.vsi_inputAddr        = '0;
        bus.vsi_inputData        = '0;
        bus.vsi_bw               = '0;
        bus.vsi_outputChipSelect = 1'b0;
        bus.vsi_outputAddr       = '0;
        case (r_state)
            ST_INIT: begin
                if (vsi_reset_n) begin
                    bus.vsi_inputChipSelect = 1'b1;
                    bus.vsi_inputAddr       = r_init_cnt;
                    bus.vsi_bw              = '1;
                    if (r_init_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wgnt) begin
                    bus.vsi_inputChipSelect = 1'b1;
                    bus.vsi_inputAddr       = w_addr[w_wid];
                    bus.vsi_inputData       = w_data[w_wid];
                    bus.vsi_bw              = w_bw[w_wid];
                end
                if (w_rissue) begin
                    bus.vsi_outputChipSelect = 1'b1;
                    bus.vsi_outputAddr       = w_addr[w_rid];
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            r_init_cnt <= '0;
            r_rr_w     <= 1'b0;
            r_rr_r     <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if (w_wgnt) r_rr_w <= ~w_wid;
            if (w_racc) r_rr_r <= ~w_rid;
            r_rsp_vld <= w_racc;
            r_rsp_id  <= w_rid;
        end
    end

    assign bus.c0_req_ready = (w_wgnt & ~w_wid) | (w_racc & ~w_rid);
    assign bus.c1_req_ready = (w_wgnt &  w_wid) | (w_racc &  w_rid);

    assign bus.c0_rsp_valid = r_rsp_vld & ~r_rsp_id;
    assign bus.c1_rsp_valid = r_rsp_vld &  r_rsp_id;
    assign bus.c0_rsp_data  = bus.c0_rsp_valid ? w_rdata : '0;
    assign bus.c1_rsp_data  = bus.c1_rsp_valid ? w_rdata : '0;

    assign bus.init_done = w_run;
endmodule

// File: tb/tb_bank_arbiter.sv
// Self-checking bench for bank_arbiter: directed scenarios plus randomized traffic
// against a memory-array reference model; the SRAM bank is emulated here.
module tb_bank_arbiter;
    localparam int AW    = 7;
    localparam int DW    = 128;
    localparam int DEPTH = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    bank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

    bank_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_ON_RESET(1)
    ) dut (
        .vsi_clk    (clk),
        .vsi_reset_n(rst_n),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    // Bank emulation: bit-masked write, one-cycle registered read.
    logic [DW-1:0] bank [DEPTH];
    always @(posedge clk) begin
        if (bif.vsi_inputChipSelect)
            bank[bif.vsi_inputAddr] <= (bank[bif.vsi_inputAddr] & ~bif.vsi_bw) |
                                       (bif.vsi_inputData & bif.vsi_bw);
        if (bif.vsi_outputChipSelect)
            bif.vsi_outputData <= bank[bif.vsi_outputAddr];
    end

    task automatic set_req(input int k, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m);
        if (k == 0) begin
            bif.c0_req_valid = v; bif.c0_req_write = w; bif.c0_req_addr = a;
            bif.c0_req_data  = d; bif.c0_req_bw    = m;
        end else begin
            bif.c1_req_valid = v; bif.c1_req_write = w; bif.c1_req_addr = a;
            bif.c1_req_data  = d; bif.c1_req_bw    = m;
        end
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset_init();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH) @(negedge clk);
    endtask

    function automatic int pick(input bit want0, input bit want1, input int ptr);
        if (want0 && want1) return ptr;
        if (want0) return 0;
        if (want1) return 1;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_req(0, 1'b1, 1'b0, 7'd3, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({bif.init_done, bif.c0_req_ready, bif.c1_req_ready, bif.vsi_inputChipSelect,
             bif.vsi_outputChipSelect, bif.c0_rsp_valid, bif.c1_rsp_valid} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: done=%b rdy=%b%b ics=%b ocs=%b rv=%b%b, want all 0",
                     bif.init_done, bif.c0_req_ready, bif.c1_req_ready, bif.vsi_inputChipSelect,
                     bif.vsi_outputChipSelect, bif.c0_rsp_valid, bif.c1_rsp_valid);
        end
    endtask

    task automatic test_init();
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b1, 7'd10, 128'hF, '1);
        set_req(1, 1'b1, 1'b0, 7'd11, '0, '0);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (bif.vsi_inputChipSelect !== 1'b1 || bif.vsi_inputAddr !== AW'(i) ||
                bif.vsi_bw !== {DW{1'b1}} || bif.vsi_inputData !== '0 ||
                bif.c0_req_ready !== 1'b0 || bif.c1_req_ready !== 1'b0 ||
                bif.vsi_outputChipSelect !== 1'b0 || bif.init_done !== 1'b0) begin
                n_err++;
                $display("FAIL init_sweep[%0d]: cs=%b addr=%0d bw_ones=%b data0=%b rdy=%b%b ocs=%b done=%b",
                         i, bif.vsi_inputChipSelect, bif.vsi_inputAddr, bif.vsi_bw == {DW{1'b1}},
                         bif.vsi_inputData == '0, bif.c0_req_ready, bif.c1_req_ready,
                         bif.vsi_outputChipSelect, bif.init_done);
            end
            @(negedge clk);
            if (i == DEPTH - 1) idle();
            #1;
        end
        n_vec++;
        if (bif.init_done !== 1'b1) begin
            n_err++;
            $display("FAIL init_done_after_sweep: got %b want 1", bif.init_done);
        end
    endtask

    task automatic test_init_read();
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd5, '0, '0);
        #1;
        n_vec++;
        if (bif.c0_req_ready !== 1'b1 || bif.vsi_outputChipSelect !== 1'b1 || bif.vsi_outputAddr !== 7'd5) begin
            n_err++;
            $display("FAIL init_read_issue: rdy=%b ocs=%b oaddr=%0d want 1 1 5",
                     bif.c0_req_ready, bif.vsi_outputChipSelect, bif.vsi_outputAddr);
        end
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== '0 || bif.c1_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL init_read_rsp: v0=%b d0=%h v1=%b want 1 0 0",
                     bif.c0_rsp_valid, bif.c0_rsp_data, bif.c1_rsp_valid);
        end
    endtask

    task automatic test_alt_writes();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b1, 7'd1, 128'hA, '1);
            set_req(1, 1'b1, 1'b1, 7'd2, 128'hB, '1);
            #1;
            n_vec++;
            if (bif.c0_req_ready !== ((i % 2) == 0) || bif.c1_req_ready !== ((i % 2) == 1)) begin
                n_err++;
                $display("FAIL rr_write[%0d]: rdy0=%b rdy1=%b want %b %b", i,
                         bif.c0_req_ready, bif.c1_req_ready, (i % 2) == 0, (i % 2) == 1);
            end
        end
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 1'b0, 7'd1, '0, '0);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd2, '0, '0);
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'hA) begin
            n_err++;
            $display("FAIL rr_readback_1: v=%b d=%h want 1 a", bif.c0_rsp_valid, bif.c0_rsp_data);
        end
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'hB) begin
            n_err++;
            $display("FAIL rr_readback_2: v=%b d=%h want 1 b", bif.c0_rsp_valid, bif.c0_rsp_data);
        end
    endtask

    task automatic test_parallel_rw();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 7'd3, 128'h33, '1);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd3, '0, '0);
        set_req(1, 1'b1, 1'b1, 7'd4, 128'h44, '1);
        #1;
        n_vec++;
        if (bif.c0_req_ready !== 1'b1 || bif.c1_req_ready !== 1'b1 ||
            bif.vsi_outputAddr !== 7'd3 || bif.vsi_inputAddr !== 7'd4) begin
            n_err++;
            $display("FAIL parallel_issue: rdy=%b%b oaddr=%0d iaddr=%0d want 11 3 4",
                     bif.c0_req_ready, bif.c1_req_ready, bif.vsi_outputAddr, bif.vsi_inputAddr);
        end
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'h33 || bif.c1_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL parallel_rsp: v0=%b d0=%h v1=%b want 1 33 0",
                     bif.c0_rsp_valid, bif.c0_rsp_data, bif.c1_rsp_valid);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd7, '0, '0);
        set_req(1, 1'b1, 1'b1, 7'd7, 128'h55, '1);
        #1;
`ifdef BANK_ARB_FWD_EN
        n_vec++;
        if (bif.c0_req_ready !== 1'b1 || bif.c1_req_ready !== 1'b1 || bif.vsi_outputChipSelect !== 1'b0) begin
            n_err++;
            $display("FAIL coll_fwd_accept: rdy=%b%b ocs=%b want 11 0",
                     bif.c0_req_ready, bif.c1_req_ready, bif.vsi_outputChipSelect);
        end
        @(negedge clk);
        idle();
`else
        n_vec++;
        if (bif.c0_req_ready !== 1'b0 || bif.c1_req_ready !== 1'b1 || bif.vsi_outputChipSelect !== 1'b0) begin
            n_err++;
            $display("FAIL coll_stall: rdy=%b%b ocs=%b want 01 0",
                     bif.c0_req_ready, bif.c1_req_ready, bif.vsi_outputChipSelect);
        end
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b0 || bif.c0_req_ready !== 1'b1 || bif.vsi_outputAddr !== 7'd7) begin
            n_err++;
            $display("FAIL coll_retry: v0=%b rdy0=%b oaddr=%0d want 0 1 7",
                     bif.c0_rsp_valid, bif.c0_req_ready, bif.vsi_outputAddr);
        end
        @(negedge clk);
        idle();
`endif
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'h55) begin
            n_err++;
            $display("FAIL coll_rsp: v=%b d=%h want 1 55", bif.c0_rsp_valid, bif.c0_rsp_data);
        end
        // A partial-mask collision stalls in every build.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd8, '0, '0);
        set_req(1, 1'b1, 1'b1, 7'd8, 128'h99, 128'hFF);
        #1;
        n_vec++;
        if (bif.c0_req_ready !== 1'b0 || bif.c1_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL coll_partial_stall: rdy=%b%b want 01", bif.c0_req_ready, bif.c1_req_ready);
        end
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'h99) begin
            n_err++;
            $display("FAIL coll_partial_rsp: v=%b d=%h want 1 99", bif.c0_rsp_valid, bif.c0_rsp_data);
        end
    endtask

    task automatic test_partial_write();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 7'd9, 128'h1234, 128'hFF);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 7'd9, '0, '0);
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1 || bif.c0_rsp_data !== 128'h34) begin
            n_err++;
            $display("FAIL partial_write: v=%b d=%h want 1 34", bif.c0_rsp_valid, bif.c0_rsp_data);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [DEPTH];
        logic          v [2], w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2], m [2];
        logic          act_rdy [2], act_v [2];
        logic [DW-1:0] act_d [2];
        logic          exp_rdy [2];
        int            rrw, rrr, wk, rk;
        bit            coll, fwd, racc, pend_v;
        int            pend_k;
        logic [DW-1:0] pend_d, exp_d;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rrw = 0; rrr = 0; pend_v = 0; pend_k = 0; pend_d = '0;
        do_reset_init();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) @(negedge clk);
            act_v[0] = bif.c0_rsp_valid; act_d[0] = bif.c0_rsp_data;
            act_v[1] = bif.c1_rsp_valid; act_d[1] = bif.c1_rsp_data;
            for (int k = 0; k < 2; k++) begin
                exp_d = (pend_v && pend_k == k) ? pend_d : '0;
                n_vec++;
                if (act_v[k] !== (pend_v && pend_k == k) || act_d[k] !== exp_d) begin
                    n_err++;
                    $display("FAIL rand_rsp c%0d cyc %0d: v=%b d=%h want v=%b d=%h",
                             k, cyc, act_v[k], act_d[k], pend_v && pend_k == k, exp_d);
                end
            end
            for (int k = 0; k < 2; k++) begin
                v[k] = ($urandom_range(3) != 0);
                w[k] = $urandom_range(1) != 0;
                a[k] = AW'($urandom_range(7));
                d[k] = {$urandom, $urandom, $urandom, $urandom};
                m[k] = ($urandom_range(1) != 0) ? {DW{1'b1}} : {$urandom, $urandom, $urandom, $urandom};
                set_req(k, v[k], w[k], a[k], d[k], m[k]);
            end
            #1;
            wk   = pick(v[0] && w[0], v[1] && w[1], rrw);
            rk   = pick(v[0] && !w[0], v[1] && !w[1], rrr);
            coll = (wk >= 0) && (rk >= 0) && (a[wk] == a[rk]);
`ifdef BANK_ARB_FWD_EN
            fwd  = coll && (m[wk] == {DW{1'b1}});
`else
            fwd  = 1'b0;
`endif
            racc = (rk >= 0) && (!coll || fwd);
            for (int k = 0; k < 2; k++) exp_rdy[k] = (wk == k) || (racc && rk == k);
            act_rdy[0] = bif.c0_req_ready;
            act_rdy[1] = bif.c1_req_ready;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (act_rdy[k] !== exp_rdy[k]) begin
                    n_err++;
                    $display("FAIL rand_ready c%0d cyc %0d: got %b want %b", k, cyc, act_rdy[k], exp_rdy[k]);
                end
            end
            pend_v = racc;
            pend_k = (rk >= 0) ? rk : 0;
            pend_d = fwd ? d[wk] : ((rk >= 0) ? ref_mem[a[rk]] : '0);
            if (racc) rrr = 1 - rk;
            if (wk >= 0) begin
                ref_mem[a[wk]] = (ref_mem[a[wk]] & ~m[wk]) | (d[wk] & m[wk]);
                rrw = 1 - wk;
            end
        end
        @(negedge clk);
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== (pend_v && pend_k == 0) || bif.c1_rsp_valid !== (pend_v && pend_k == 1)) begin
            n_err++;
            $display("FAIL rand_last_rsp: v=%b%b want %b%b", bif.c0_rsp_valid, bif.c1_rsp_valid,
                     pend_v && pend_k == 0, pend_v && pend_k == 1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 1'b0, 7'd1, '0, '0);
        @(posedge clk);
        #1;
        idle();
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pending: v=%b want 1", bif.c0_rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bif.c0_rsp_valid !== 1'b0 || bif.init_done !== 1'b0 || bif.c0_rsp_data !== '0) begin
            n_err++;
            $display("FAIL midrst_drop: v=%b done=%b d=%h want 0 0 0",
                     bif.c0_rsp_valid, bif.init_done, bif.c0_rsp_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bif.vsi_inputChipSelect !== 1'b1 || bif.vsi_inputAddr !== 7'd0) begin
            n_err++;
            $display("FAIL midrst_init0: cs=%b addr=%0d want 1 0", bif.vsi_inputChipSelect, bif.vsi_inputAddr);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (bif.vsi_inputAddr !== 7'd1 || bif.init_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_init1: addr=%0d done=%b want 1 0", bif.vsi_inputAddr, bif.init_done);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init();
        test_init_read();
        test_alt_writes();
        test_parallel_rw();
        test_collision();
        test_partial_write();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
